program_feeder: RTL and testbench
=================================

PROGRAM_FEEDER -- requirements
Module: program_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, instruction/data word width.
REQ-002 SHALL have parameter MEM_DEPTH, default 64, program store depth in words (power of two).
REQ-003 SHALL have derived parameter ADDR_WIDTH, default $clog2(MEM_DEPTH), word index width.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port srst  input  1  reset; synchronous and active-high.
REQ-006 SHALL have port load_valid  input  1  load word offered.
REQ-007 SHALL have port load_ready  output  1  feeder accepts load word.
REQ-008 SHALL have port load_data  input  DATA_WIDTH  program word.
REQ-009 SHALL have port load_last  input  1  final program word.
REQ-010 SHALL have port start  input  1  begin execution pulse.
REQ-011 SHALL have port pc  input  DATA_WIDTH  byte address from core program counter.
REQ-012 SHALL have port stall  input  1  core not consuming; hold instruction.
REQ-013 SHALL have port instruction  output  DATA_WIDTH  registered word to core instruction input.
REQ-014 SHALL have port instr_valid  output  1  instruction is a real fetched word.
REQ-015 SHALL have port halted  output  1  feeder in HALT.
REQ-016 SHALL have port load_count  output  ADDR_WIDTH+1  words stored.
REQ-017 SHALL have port error  output  1  sticky fault flag.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, LOADED, RUN, HALT.
REQ-019 load_ready SHALL be 1 only in IDLE and LOAD; a transfer occurs when load_valid and load_ready are both 1 on a clock edge.
REQ-020 Each transfer SHALL write load_data to store[load_count] and increment load_count by 1.
REQ-021 IDLE -> LOAD on a transfer with load_last=0; IDLE or LOAD -> LOADED on a transfer with load_last=1.
REQ-022 A transfer that makes load_count equal MEM_DEPTH with load_last=0 SHALL go to LOADED and set error (truncation).
REQ-023 start SHALL be ignored in IDLE, LOAD, RUN and HALT; in LOADED it moves to RUN next edge.
REQ-024 In RUN with stall=0, instruction SHALL load store[pc[ADDR_WIDTH+1:2]] and instr_valid=1 one cycle after pc is presented (latency 1).
REQ-025 In RUN with stall=1, instruction and instr_valid SHALL hold their values.
REQ-026 In RUN with stall=0, pc[1:0]!=0 SHALL set error, go to HALT, and drive NOP.
REQ-027 In RUN with stall=0, word index >= load_count (including pc beyond ADDR_WIDTH range) SHALL go to HALT without setting error.
REQ-028 In all states other than RUN, instruction SHALL be 32'h0000_0013 (NOP) and instr_valid=0.
REQ-029 The stall check SHALL take priority over the range and alignment checks: under stall, no fault is evaluated.
REQ-030 HALT SHALL be exited only by srst; halted=1 exactly while in HALT.
REQ-031 error SHALL remain set until srst.

Reset
REQ-032 srst=1 at an edge SHALL force state IDLE, load_count=0, instruction=NOP, instr_valid=0, halted=0, error=0, from any state including mid-load and mid-run.
REQ-033 Store contents SHALL NOT be cleared by reset; the range check of REQ-027 masks stale words.
REQ-034 load_ready SHALL be 1 in the first cycle after reset is released.

Structure
REQ-035 Shared package SHALL hold the state enum type, the NOP constant 32'h0000_0013, and DATA_WIDTH/MEM_DEPTH defaults.
REQ-036 The store SHALL be a sub-module program_store (one write port, one synchronous read port) instantiated once; FSM and checks reside in program_feeder.

Verification
REQ-037 Load 3 words (0x00500093, 0x00A00113, 0x002081B3, last on third) then start; pc=0,4,8 -> instruction equals those words on cycles +1,+2,+3; instr_valid=1.
REQ-038 In RUN, pc=4, stall=1 for 3 cycles -> instruction holds the prior word; error stays 0.
REQ-039 In RUN, pc=12 with load_count=3 -> next cycle halted=1, instruction=0x00000013, instr_valid=0, error=0.
REQ-040 In RUN, pc=6 -> halted=1, error=1; start pulse afterwards -> no change.
REQ-041 Stream MEM_DEPTH words with load_last=0 -> LOADED, error=1, load_ready=0, load_count=MEM_DEPTH.
REQ-042 Assert srst mid-load (after 2 words) -> next cycle load_count=0, load_ready=1, error=0, instr_valid=0.

Source files
------------

// File: rtl/program_feeder_pkg.sv
// Shared types and constants for the program feeder: FSM state encoding,
// the RISC-V NOP word and default sizing.
package program_feeder_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int MEM_DEPTH_DEF  = 64;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LOADED,
    RUN,
    HALT
  } state_e;

endpackage

// File: rtl/program_feeder_store.sv
// Program word store: one write port, one synchronous read port with a read
// enable so the last fetched word holds while the core is stalled.
module program_store #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 64,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Contents deliberately survive reset; the feeder masks stale words.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/program_feeder.sv
// Loads a program over a valid/ready stream, then serves instruction words
// to a core by program counter, halting on out-of-range or misaligned fetches.
module program_feeder
  import program_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int MEM_DEPTH  = MEM_DEPTH_DEF,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic                  stall,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic                  instr_valid,
  output logic                  halted,
  output logic [ADDR_WIDTH:0]   load_count,
  output logic                  error
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  error_q, error_d;
  logic                  valid_q, valid_d;
  logic                  storeWe, storeRe;
  logic [DATA_WIDTH-1:0] storeRdata;
  logic [DATA_WIDTH-3:0] wordIdx;
  logic                  misaligned, inRange, xfer;

  program_store #(
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_store (
    .clk    (clk),
    .we_i   (storeWe),
    .waddr_i(count_q[ADDR_WIDTH-1:0]),
    .wdata_i(load_data),
    .re_i   (storeRe),
    .raddr_i(pc[ADDR_WIDTH+1:2]),
    .rdata_o(storeRdata)
  );

  // The full upper pc field is compared so addresses past the store wrap to HALT.
  assign wordIdx    = pc[DATA_WIDTH-1:2];
  assign misaligned = (pc[1:0] != 2'b00);
  assign inRange    = (wordIdx < (DATA_WIDTH-2)'(count_q));
  assign load_ready = (state_q == IDLE) || (state_q == LOAD);
  assign xfer       = load_valid && load_ready;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    error_d = error_q;
    valid_d = valid_q;
    storeWe = 1'b0;
    storeRe = 1'b0;
    case (state_q)
      IDLE, LOAD: begin
        if (xfer) begin
          storeWe = 1'b1;
          count_d = count_q + 1'b1;
          if (load_last) begin
            state_d = LOADED;
          end else if (count_q == (ADDR_WIDTH+1)'(MEM_DEPTH-1)) begin
            state_d = LOADED;
            error_d = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOADED: begin
        if (start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // Under stall nothing is checked and the fetched word is held.
        if (!stall) begin
          if (misaligned) begin
            error_d = 1'b1;
            state_d = HALT;
            valid_d = 1'b0;
          end else if (!inRange) begin
            state_d = HALT;
            valid_d = 1'b0;
          end else begin
            storeRe = 1'b1;
            valid_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= IDLE;
      count_q <= '0;
      error_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      error_q <= error_d;
      valid_q <= valid_d;
    end
  end

  assign instruction = valid_q ? storeRdata : DATA_WIDTH'(NOP);
  assign instr_valid = valid_q;
  assign halted      = (state_q == HALT);
  assign load_count  = count_q;
  assign error       = error_q;

endmodule

// File: tb/tb_program_feeder.sv
// Randomised and directed bench for program_feeder, checked every cycle
// against a behavioural model of the loader and fetch rules.
module tb_program_feeder;

  localparam int DW = 32;
  localparam int DEPTH = 64;
  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] NOPW = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          srst = 1'b1;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [DW-1:0] load_data = '0;
  logic          load_last = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] pc = '0;
  logic          stall = 1'b0;
  logic [DW-1:0] instruction;
  logic          instr_valid;
  logic          halted;
  logic [AW:0]   load_count;
  logic          error;

  int compared = 0;
  int mismatched = 0;

  program_feeder #(.DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .srst       (srst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_last  (load_last),
    .start      (start),
    .pc         (pc),
    .stall      (stall),
    .instruction(instruction),
    .instr_valid(instr_valid),
    .halted     (halted),
    .load_count (load_count),
    .error      (error)
  );

  always #5 clk = ~clk;

  // Behavioural model: a loaded program plus a few phase flags.
  logic [31:0] mem [DEPTH];
  bit          mKnown = 0;
  bit          mDone, mRun, mHalt, mErr, mValid;
  int          mCount;
  logic [31:0] mInstr;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  always @(posedge clk) begin
    if (srst) begin
      mKnown = 1; mDone = 0; mRun = 0; mHalt = 0; mErr = 0; mValid = 0; mCount = 0;
    end else if (mKnown) begin
      if (!mDone) begin
        if (load_valid) begin
          mem[mCount] = load_data;
          mCount++;
          if (load_last) mDone = 1;
          else if (mCount == DEPTH) begin mDone = 1; mErr = 1; end
        end
      end else if (!mRun && !mHalt) begin
        if (start) mRun = 1;
      end else if (mRun && !stall) begin
        if (pc % 4 != 0) begin
          mErr = 1; mRun = 0; mHalt = 1; mValid = 0;
        end else if (int'(pc / 4) >= mCount) begin
          mRun = 0; mHalt = 1; mValid = 0;
        end else begin
          mValid = 1; mInstr = mem[pc / 4];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mKnown) begin
      checkOutput("load_ready", load_ready, !mDone);
      checkOutput("load_count", load_count, mCount);
      checkOutput("instr_valid", instr_valid, mValid);
      checkOutput("instruction", instruction, mValid ? mInstr : NOPW);
      checkOutput("halted", halted, mHalt);
      checkOutput("error", error, mErr);
    end
  end

  task automatic doReset();
    srst = 1'b1; load_valid = 1'b0; load_last = 1'b0; start = 1'b0; stall = 1'b0; pc = '0;
    applyStimulus(2);
    srst = 1'b0;
  endtask

  task automatic loadWord(input logic [31:0] d, input logic last);
    load_valid = 1'b1; load_data = d; load_last = last;
    applyStimulus(1);
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] addr, input logic stl);
    pc = addr; stall = stl;
    applyStimulus(1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int L, sent, budget, idx, r;
    bit trunc;

    // Reset values and ready right after release.
    doReset();
    checkOutput("rst_ready", load_ready, 1'b1);
    checkOutput("rst_count", load_count, 0);
    checkOutput("rst_instr", instruction, 32'h0000_0013);
    checkOutput("rst_valid", instr_valid, 1'b0);
    checkOutput("rst_halted", halted, 1'b0);
    checkOutput("rst_error", error, 1'b0);

    // Three-word program fetched in order.
    loadWord(32'h0050_0093, 1'b0);
    loadWord(32'h00A0_0113, 1'b0);
    loadWord(32'h0020_81B3, 1'b1);
    checkOutput("loaded_count", load_count, 3);
    checkOutput("loaded_ready", load_ready, 1'b0);
    start = 1'b1; applyStimulus(1); start = 1'b0;
    checkOutput("run_first_valid", instr_valid, 1'b0);
    fetch(32'd0, 1'b0);
    checkOutput("fetch0", instruction, 32'h0050_0093);
    checkOutput("fetch0_valid", instr_valid, 1'b1);
    fetch(32'd4, 1'b0);
    checkOutput("fetch4", instruction, 32'h00A0_0113);
    fetch(32'd8, 1'b0);
    checkOutput("fetch8", instruction, 32'h0020_81B3);

    // Stall holds the prior word.
    for (int i = 0; i < 3; i++) begin
      fetch(32'd4, 1'b1);
      checkOutput("stall_hold", instruction, 32'h0020_81B3);
      checkOutput("stall_err", error, 1'b0);
    end

    // Out-of-range pc halts cleanly.
    fetch(32'd12, 1'b0);
    checkOutput("oor_halted", halted, 1'b1);
    checkOutput("oor_instr", instruction, 32'h0000_0013);
    checkOutput("oor_valid", instr_valid, 1'b0);
    checkOutput("oor_error", error, 1'b0);

    // Misaligned pc halts with error; start afterwards is ignored.
    doReset();
    loadWord(32'h1111_1111, 1'b0);
    loadWord(32'h2222_2222, 1'b1);
    start = 1'b1; applyStimulus(1); start = 1'b0;
    fetch(32'd6, 1'b0);
    checkOutput("mis_halted", halted, 1'b1);
    checkOutput("mis_error", error, 1'b1);
    start = 1'b1; applyStimulus(2); start = 1'b0;
    checkOutput("mis_start_halted", halted, 1'b1);
    checkOutput("mis_start_error", error, 1'b1);
    checkOutput("mis_start_valid", instr_valid, 1'b0);

    // Truncation on a full store.
    doReset();
    for (int i = 0; i < DEPTH; i++) loadWord($urandom, 1'b0);
    checkOutput("trunc_count", load_count, DEPTH);
    checkOutput("trunc_ready", load_ready, 1'b0);
    checkOutput("trunc_error", error, 1'b1);
    loadWord($urandom, 1'b0);
    checkOutput("trunc_extra", load_count, DEPTH);

    // Reset mid-load.
    doReset();
    loadWord(32'hAAAA_0001, 1'b0);
    loadWord(32'hAAAA_0002, 1'b0);
    srst = 1'b1; applyStimulus(1); srst = 1'b0;
    checkOutput("midrst_count", load_count, 0);
    checkOutput("midrst_ready", load_ready, 1'b1);
    checkOutput("midrst_error", error, 1'b0);
    checkOutput("midrst_valid", instr_valid, 1'b0);

    // Randomised sessions.
    for (int s = 0; s < 30; s++) begin
      doReset();
      trunc = ($urandom % 5 == 0);
      L = trunc ? DEPTH : int'($urandom_range(1, DEPTH));
      sent = 0; budget = 0;
      while (!mDone && budget < 6 * DEPTH) begin
        load_valid = ($urandom % 3 != 0);
        load_data  = $urandom;
        load_last  = !trunc && (sent == L - 1);
        start      = ($urandom % 8 == 0);
        pc         = $urandom;
        stall      = $urandom[0];
        applyStimulus(1);
        if (load_valid) sent++;
        budget++;
      end
      load_valid = 1'b0; load_last = 1'b0;
      checkOutput("rand_load_done", load_ready, 1'b0);
      start = 1'b1; stall = 1'b0; applyStimulus(1); start = 1'b0;
      for (int c = 0; c < 50; c++) begin
        r = int'($urandom % 16);
        idx = int'($urandom_range(0, mCount - 1));
        if (r == 0) pc = 32'(idx * 4 + int'($urandom_range(1, 3)));
        else if (r == 1) pc = 32'(int'($urandom_range(mCount, mCount + 8)) * 4);
        else if (r == 2) pc = $urandom;
        else pc = 32'(idx * 4);
        stall = ($urandom % 4 == 0);
        start = ($urandom % 10 == 0);
        applyStimulus(1);
      end
      start = 1'b0; stall = 1'b0;
    end

    applyStimulus(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
